gc_frame_receiver: RTL and testbench

- Parametrised receiver for the GameCube controller one-wire reply. Successor to the fixed 81-bit poll decoder.
- Sits after the console-side request transmitter: armed when a request finishes, decodes the controller's pulse-width-coded reply, and latches a whole validated frame.
- Adds several behaviours the old block lacked: stop-bit check, error reporting, controller-presence tracking, and a double-buffered output that never shows a partial frame.

---
 rtl/gc_frame_receiver_if.sv | 37 +++
 rtl/gc_frame_receiver.sv | 272 +++++++++++++++++++++++++++
 tb/tb_gc_frame_receiver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gc_frame_receiver_if.sv
// Bus between the console-side controller and the one-wire reply receiver.
// master: the console logic that drives the line and arms the receiver.
// slave:  the receiver, which returns validated frames and status.
interface gc_frame_receiver_if #(
    parameter int FRAME_BITS = 64
);
    logic                  line_in;
    logic                  arm;
    logic [FRAME_BITS-1:0] data_out;
    logic                  frame_valid;
    logic                  frame_err;
    logic [1:0]            err_code;
    logic                  busy;
    logic                  present;

    modport master (
        output line_in,
        output arm,
        input  data_out,
        input  frame_valid,
        input  frame_err,
        input  err_code,
        input  busy,
        input  present
    );

    modport slave (
        input  line_in,
        input  arm,
        output data_out,
        output frame_valid,
        output frame_err,
        output err_code,
        output busy,
        output present
    );
endinterface

// File: rtl/gc_frame_receiver.sv
// GameCube controller reply receiver.
// Decodes the pulse-width-coded reply that follows a console request and
// publishes only whole frames that ended with a valid stop bit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for arm; line activity ignored (console request)
// WAIT_START | armed, waiting for the first falling edge of the reply
// LOW        | measuring a low pulse (bit value or stop bit)
// HIGH       | measuring the high gap between two low pulses
// DONE       | one clock: publish frame, clear failure history
// ERROR      | one clock: report cause, bump failure counter
module gc_frame_receiver #(
    parameter int FRAME_BITS        = 64,
    parameter int THRESH_CLKS       = 50,
    parameter int LOW_MAX_CLKS      = 120,
    parameter int GAP_MAX_CLKS      = 250,
    parameter int RESP_TIMEOUT_CLKS = 2500,
    parameter int NO_CON_LIMIT      = 4
) (
    input  logic clk,
    input  logic reset,
    gc_frame_receiver_if.slave rx
);

    localparam int LOW_W  = $clog2(LOW_MAX_CLKS + 2);
    localparam int HIGH_W = $clog2(GAP_MAX_CLKS + 2);
    localparam int TMR_W  = $clog2(RESP_TIMEOUT_CLKS + 1);
    localparam int IDX_W  = $clog2(FRAME_BITS + 1);
    localparam int FAIL_W = $clog2(NO_CON_LIMIT + 1);

    localparam logic [LOW_W-1:0]  LOW_THRESH = LOW_W'(THRESH_CLKS);
    localparam logic [LOW_W-1:0]  LOW_MAX    = LOW_W'(LOW_MAX_CLKS);
    localparam logic [LOW_W-1:0]  LOW_SAT    = LOW_W'(LOW_MAX_CLKS + 1);
    localparam logic [HIGH_W-1:0] HIGH_MAX   = HIGH_W'(GAP_MAX_CLKS);
    localparam logic [HIGH_W-1:0] HIGH_SAT   = HIGH_W'(GAP_MAX_CLKS + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(RESP_TIMEOUT_CLKS);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FRAME_BITS);
    localparam logic [FAIL_W-1:0] FAIL_LIM   = FAIL_W'(NO_CON_LIMIT);
    localparam logic [FAIL_W-1:0] FAIL_DROP  = FAIL_W'(NO_CON_LIMIT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NO_RESP = 2'd1;
    localparam logic [1:0] ERR_LOW     = 2'd2;
    localparam logic [1:0] ERR_GAP     = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        LOW        = 3'd2,
        HIGH       = 3'd3,
        DONE       = 3'd4,
        ERROR      = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic sync_1;
    logic sync_2;
    logic sync_3;
    logic fall;
    logic rise;

    logic [TMR_W-1:0]      resp_timer;
    logic [LOW_W-1:0]      low_cnt;
    logic [HIGH_W-1:0]     high_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [1:0]            cause_q;
    logic [FAIL_W-1:0]     fail_cnt;

    logic [FRAME_BITS-1:0] data_out_q;
    logic                  frame_valid_q;
    logic                  frame_err_q;
    logic [1:0]            err_code_q;
    logic                  present_q;

    logic       ld_timer;
    logic       dec_timer;
    logic       ld_low;
    logic       inc_low;
    logic       ld_high;
    logic       inc_high;
    logic       clr_frame;
    logic       shift_en;
    logic       shift_bit;
    logic       set_cause;
    logic [1:0] cause_val;

    // Both edges go through the same three flops, so measured widths equal
    // the true widths on the wire.
    assign fall = sync_3 & ~sync_2;
    assign rise = ~sync_3 & sync_2;

    // Synchroniser and edge-detect flop; line idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
        end else begin
            sync_1 <= rx.line_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    // State register; reset has priority over a coincident arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes. Over-length checks win over a
    // coincident edge so a pulse one clock too long is never accepted.
    always_comb begin
        state_next = state;
        ld_timer   = 1'b0;
        dec_timer  = 1'b0;
        ld_low     = 1'b0;
        inc_low    = 1'b0;
        ld_high    = 1'b0;
        inc_high   = 1'b0;
        clr_frame  = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        set_cause  = 1'b0;
        cause_val  = ERR_NONE;
        case (state)
            IDLE: begin
                if (rx.arm) begin
                    state_next = WAIT_START;
                    clr_frame  = 1'b1;
                    ld_timer   = 1'b1;
                end
            end
            WAIT_START: begin
                dec_timer = 1'b1;
                if (fall) begin
                    state_next = LOW;
                    ld_low     = 1'b1;
                end else if (resp_timer == '0) begin
                    state_next = ERROR;
                    set_cause  = 1'b1;
                    cause_val  = ERR_NO_RESP;
                end
            end
            LOW: begin
                inc_low = 1'b1;
                if (low_cnt > LOW_MAX) begin
                    state_next = ERROR;
                    set_cause  = 1'b1;
                    cause_val  = ERR_LOW;
                end else if (rise) begin
                    if (bit_idx < IDX_LAST) begin
                        shift_en   = 1'b1;
                        shift_bit  = (low_cnt > LOW_THRESH) ? 1'b0 : 1'b1;
                        state_next = HIGH;
                        ld_high    = 1'b1;
                    end else if (low_cnt > LOW_THRESH) begin
                        state_next = ERROR;
                        set_cause  = 1'b1;
                        cause_val  = ERR_GAP;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            HIGH: begin
                inc_high = 1'b1;
                if (high_cnt > HIGH_MAX) begin
                    state_next = ERROR;
                    set_cause  = 1'b1;
                    cause_val  = ERR_GAP;
                end else if (fall) begin
                    state_next = LOW;
                    ld_low     = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response timeout (down-counter) and saturating pulse-width counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_timer <= '0;
            low_cnt    <= '0;
            high_cnt   <= '0;
        end else begin
            if (ld_timer) begin
                resp_timer <= TMR_LOAD;
            end else if (dec_timer && resp_timer != '0) begin
                resp_timer <= resp_timer - TMR_W'(1);
            end
            if (ld_low) begin
                low_cnt <= LOW_W'(1);
            end else if (inc_low && low_cnt != LOW_SAT) begin
                low_cnt <= low_cnt + LOW_W'(1);
            end
            if (ld_high) begin
                high_cnt <= HIGH_W'(1);
            end else if (inc_high && high_cnt != HIGH_SAT) begin
                high_cnt <= high_cnt + HIGH_W'(1);
            end
        end
    end

    // Bit collection: first received bit ends up at the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            cause_q   <= ERR_NONE;
        end else begin
            if (clr_frame) begin
                shift_reg <= '0;
                bit_idx   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], shift_bit};
                bit_idx   <= bit_idx + IDX_W'(1);
            end
            if (set_cause) begin
                cause_q <= cause_val;
            end
        end
    end

    // Registered outputs: the strobe and its data/status appear together,
    // and data_out only ever changes to a complete validated frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            fail_cnt      <= '0;
            present_q     <= 1'b0;
        end else begin
            frame_valid_q <= (state == DONE);
            frame_err_q   <= (state == ERROR);
            if (state == DONE) begin
                data_out_q <= shift_reg;
                err_code_q <= ERR_NONE;
                fail_cnt   <= '0;
                present_q  <= 1'b1;
            end else if (state == ERROR) begin
                err_code_q <= cause_q;
                if (fail_cnt != FAIL_LIM) begin
                    fail_cnt <= fail_cnt + FAIL_W'(1);
                end
                if (fail_cnt >= FAIL_DROP) begin
                    present_q <= 1'b0;
                end
            end
        end
    end

    assign rx.data_out    = data_out_q;
    assign rx.frame_valid = frame_valid_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.err_code    = err_code_q;
    assign rx.busy        = (state != IDLE);
    assign rx.present     = present_q;

endmodule

// File: tb/tb_gc_frame_receiver.sv
// Directed bench for gc_frame_receiver: stimulus pushes expected frame
// outcomes into a queue; a monitor pops one per frame_valid/frame_err pulse.
module tb_gc_frame_receiver;
    localparam int FB = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gc_frame_receiver_if #(.FRAME_BITS(FB)) rx_if ();

    gc_frame_receiver #(.FRAME_BITS(FB)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if.slave)
    );

    typedef struct {
        logic          is_err;
        logic [1:0]    code;
        logic [FB-1:0] data;
        logic          present;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    logic [FB-1:0] last_good;
    logic          exp_present;
    int            fail_model;

    localparam logic [FB-1:0] P1 = 64'hA5A5_0F0F_1234_8001;
    localparam logic [FB-1:0] P2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [FB-1:0] P3 = 64'hFEDC_BA98_7654_3210;
    logic [FB-1:0] p2_thr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        last_good   = '0;
        exp_present = 1'b0;
        fail_model  = 0;
    endtask

    task automatic expect_ok(input logic [FB-1:0] d);
        exp_t e;
        last_good   = d;
        fail_model  = 0;
        exp_present = 1'b1;
        e.is_err = 1'b0; e.code = 2'd0; e.data = d; e.present = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] code);
        exp_t e;
        if (fail_model < 4) fail_model++;
        if (fail_model == 4) exp_present = 1'b0;
        e.is_err = 1'b1; e.code = code; e.data = last_good; e.present = exp_present;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int lo, input int hi);
        rx_if.line_in = 1'b0;
        repeat (lo) @(negedge clk);
        rx_if.line_in = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_bits(input logic [FB-1:0] d, input int first, input int last);
        logic [FB-1:0] v;
        v = d;
        for (int i = first; i <= last; i++) begin
            if (v[FB-1-i]) drive(25, 75);
            else           drive(75, 25);
        end
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        rx_if.arm = 1'b1;
        @(negedge clk);
        rx_if.arm = 1'b0;
    endtask

    // Monitor: one expected entry per output strobe.
    always @(negedge clk) begin
        if (!reset && (rx_if.frame_valid || rx_if.frame_err)) begin
            chk("valid_err_exclusive", 128'(rx_if.frame_valid & rx_if.frame_err), 128'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual valid=%0b err=%0b required none",
                         rx_if.frame_valid, rx_if.frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_is_err", 128'(rx_if.frame_err), 128'(mon_e.is_err));
                chk("data_out", 128'(rx_if.data_out), 128'(mon_e.data));
                chk("err_code", 128'(rx_if.err_code), 128'(mon_e.code));
                chk("present", 128'(rx_if.present), 128'(mon_e.present));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        rx_if.line_in = 1'b1;
        rx_if.arm     = 1'b0;
        model_reset();
        p2_thr = {2'b10, P2[FB-3:0]};
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data_out", 128'(rx_if.data_out), 128'(0));
        chk("rst_valid", 128'(rx_if.frame_valid), 128'(0));
        chk("rst_err", 128'(rx_if.frame_err), 128'(0));
        chk("rst_err_code", 128'(rx_if.err_code), 128'(0));
        chk("rst_busy", 128'(rx_if.busy), 128'(0));
        chk("rst_present", 128'(rx_if.present), 128'(0));

        // Good frame.
        expect_ok(P1);
        arm_pulse();
        chk("busy_after_arm", 128'(rx_if.busy), 128'(1));
        send_bits(P1, 0, FB-1);
        drive(25, 40);
        chk("busy_after_frame", 128'(rx_if.busy), 128'(0));

        // Trailing pulses with no arm must be ignored.
        drive(25, 75);
        drive(75, 25);
        drive(25, 40);

        // Four no-response timeouts; present drops on the fourth.
        for (int k = 0; k < 4; k++) begin
            expect_err(2'd1);
            arm_pulse();
            repeat (2600) @(negedge clk);
        end
        chk("present_after_4_timeouts", 128'(rx_if.present), 128'(0));

        // Threshold: 50 clocks decodes 1, 51 decodes 0. A second arm mid-frame is ignored.
        expect_ok(p2_thr);
        arm_pulse();
        drive(50, 75);
        drive(51, 25);
        send_bits(P2, 2, 10);
        arm_pulse();
        send_bits(P2, 11, FB-1);
        drive(25, 40);

        // Low held 121 clocks at bit 10, then a good frame.
        expect_err(2'd2);
        arm_pulse();
        send_bits(P3, 0, 9);
        drive(121, 40);
        expect_ok(P3);
        arm_pulse();
        send_bits(P3, 0, FB-1);
        drive(25, 40);

        // Stop bit too long, then a truncated frame.
        expect_err(2'd3);
        arm_pulse();
        send_bits(P1, 0, FB-1);
        drive(75, 40);
        expect_err(2'd3);
        arm_pulse();
        send_bits(P2, 0, 29);
        repeat (300) @(negedge clk);

        // Reset in the middle of a frame.
        arm_pulse();
        send_bits(P1, 0, 39);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_data_out", 128'(rx_if.data_out), 128'(0));
        chk("midrst_present", 128'(rx_if.present), 128'(0));
        chk("midrst_busy", 128'(rx_if.busy), 128'(0));
        chk("midrst_err_code", 128'(rx_if.err_code), 128'(0));
        repeat (20) @(negedge clk);

        // Reset and arm together: reset wins.
        reset     = 1'b1;
        rx_if.arm = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        rx_if.arm = 1'b0;
        @(negedge clk);
        chk("reset_beats_arm", 128'(rx_if.busy), 128'(0));

        // Normal operation after reset.
        expect_ok(P2);
        arm_pulse();
        send_bits(P2, 0, FB-1);
        drive(25, 40);

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
